// File: rtl/pipe_stage_reg_if.sv
// Valid/ready/data channel between pipeline stages.
// The producer uses the master modport and the consumer uses the slave modport.
interface pipe_stage_reg_if #(
  parameter int unsigned DATA_W = 64
) ();
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with a valid/ready handshake on each side, plus flush.
// Optional feature macro: PIPE_SKID_EN.
//   Defined:   two entries (a main register plus a skid register). in_ready is
//              taken from registered state only.
//   Undefined: one entry. in_ready passes out_ready through combinationally.
// out_data always comes from the main register. The main register holds
// BUBBLE_VAL whenever the stage is empty.
module pipe_stage_reg #(
  parameter int unsigned       DATA_W     = 64,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  pipe_stage_reg_if.slave        in_bus,
  pipe_stage_reg_if.master       out_bus,
  output logic [1:0]             count
);

`ifdef PIPE_SKID_EN
  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;
`else
  typedef enum logic [0:0] {StEmpty, StFull} state_e;
`endif

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic              accept;
  logic              consume;

  assign out_bus.valid = (state_q != StEmpty);
  assign out_bus.data  = main_q;
  assign accept        = in_bus.valid & in_bus.ready;
  assign consume       = out_bus.valid & out_bus.ready;

`ifdef PIPE_SKID_EN
  logic [DATA_W-1:0] skid_q, skid_d;

  // in_ready is taken from registered state only. Reset and flush block new beats.
  assign in_bus.ready = ~rst & ~flush & (state_q != StTwo);
  assign count        = (state_q == StTwo) ? 2'd2 : (state_q == StOne) ? 2'd1 : 2'd0;

  // Next state: fill main first, spill to skid when stalled, refill main from skid.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      StEmpty: begin
        if (accept) begin
          state_d = StOne;
          main_d  = in_bus.data;
        end
      end
      StOne: begin
        if (accept && consume) begin
          main_d = in_bus.data;
        end else if (accept) begin
          state_d = StTwo;
          skid_d  = in_bus.data;
        end else if (consume) begin
          state_d = StEmpty;
          main_d  = BUBBLE_VAL;
        end
      end
      StTwo: begin
        if (consume) begin
          state_d = StOne;
          main_d  = skid_q;
        end
      end
      default: begin
        state_d = StEmpty;
        main_d  = BUBBLE_VAL;
      end
    endcase
    if (flush) begin
      state_d = StEmpty;
      main_d  = BUBBLE_VAL;
    end
  end

  // The skid contents are meaningless while empty, so this register is not reset.
  always_ff @(posedge clk) begin
    skid_q <= skid_d;
  end
`else
  // A full stage can take a new beat only while downstream drains the current one.
  assign in_bus.ready = ~rst & ~flush & ((state_q == StEmpty) | out_bus.ready);
  assign count        = {1'b0, state_q == StFull};

  // Next state: a single entry is replaced on accept and cleared on a lone consume.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    unique case (state_q)
      StEmpty: begin
        if (accept) begin
          state_d = StFull;
          main_d  = in_bus.data;
        end
      end
      StFull: begin
        if (accept) begin
          main_d = in_bus.data;
        end else if (consume) begin
          state_d = StEmpty;
          main_d  = BUBBLE_VAL;
        end
      end
    endcase
    if (flush) begin
      state_d = StEmpty;
      main_d  = BUBBLE_VAL;
    end
  end
`endif

  // State and main register. Synchronous reset overrides flush and both handshakes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StEmpty;
      main_q  <= BUBBLE_VAL;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
    end
  end

endmodule
